// File: rtl/axi4l_mem_responder.sv
// AXI4-Lite responder for the picorv32_axi mem bus: word RAM plus console and
// test-pass MMIO registers. One-deep AW/W buffers, bare B/R handshakes.
module axi4l_mem_responder #(
  parameter int unsigned MEM_WORDS    = 16384,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  logic              aw_full_q;
  logic [31:0]       awaddr_q;
  logic              w_full_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              bvalid_q;
  logic              console_valid_q;
  logic [7:0]        console_data_q;
  logic              tests_passed_q;
  rd_state_e         rd_state_q, rd_state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem [MEM_WORDS];

  logic              commit;
  logic              wr_ram;
  logic              wr_console;
  logic              wr_pass;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              unused_ok;

  // Protection bits carry no meaning for this target.
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot};

  assign mem_axi_awready = !aw_full_q;
  assign mem_axi_wready  = !w_full_q;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_arready = (rd_state_q == RD_IDLE);
  assign mem_axi_rvalid  = (rd_state_q == RD_RESP);
  assign mem_axi_rdata   = rdata_q;
  assign console_valid   = console_valid_q;
  assign console_data    = console_data_q;
  assign tests_passed    = tests_passed_q;

  assign commit     = aw_full_q && w_full_q && (!bvalid_q || mem_axi_bready);
  assign wr_ram     = (awaddr_q < MEM_BYTES);
  assign wr_console = (awaddr_q == CONSOLE_ADDR) && wstrb_q[0];
  assign wr_pass    = (awaddr_q == PASS_ADDR) && (wdata_q == PASS_MAGIC);
  assign wr_idx     = awaddr_q[IDX_W+1:2];
  assign rd_idx     = mem_axi_araddr[IDX_W+1:2];

  // Write side: accept and commit are exclusive per buffer (ready == !full).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full_q       <= 1'b0;
      awaddr_q        <= '0;
      w_full_q        <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      bvalid_q        <= 1'b0;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      tests_passed_q  <= 1'b0;
    end else begin
      if (mem_axi_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= mem_axi_awaddr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end

      if (mem_axi_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        wdata_q  <= mem_axi_wdata;
        wstrb_q  <= mem_axi_wstrb;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
      end else if (mem_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      console_valid_q <= commit && wr_console;
      if (commit && wr_console) begin
        console_data_q <= wdata_q[7:0];
      end
      if (commit && wr_pass) begin
        tests_passed_q <= 1'b1;
      end
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto
  // memory macros; commit is held low during reset so no store can slip in.
  always_ff @(posedge clk) begin
    if (commit && wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
    end
  end

  // Read data is captured from the pre-edge RAM, giving read-before-write.
  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (mem_axi_arvalid) begin
          rd_state_d = RD_RESP;
          if (mem_axi_araddr < MEM_BYTES) begin
            rdata_d = mem[rd_idx];
          end else if (mem_axi_araddr == PASS_ADDR) begin
            rdata_d = {31'b0, tests_passed_q};
          end else begin
            rdata_d = '0;
          end
        end
      end
      RD_RESP: begin
        if (mem_axi_rready) begin
          rd_state_d = RD_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_axi4l_mem_responder.sv
// Self-checking bench for axi4l_mem_responder: a table of write/read vectors
// plus hand-timed sequences for ordering, back-pressure, MMIO and reset.
module tb_axi4l_mem_responder;

  localparam logic [31:0] CONSOLE = 32'h1000_0000;
  localparam logic [31:0] PASS    = 32'h2000_0000;

  logic        clk;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        console_valid, tests_passed;
  logic [7:0]  console_data;

  int n_vec = 0;
  int n_bad = 0;
  int b_cnt = 0;
  int cons_cnt = 0;

  axi4l_mem_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_axi_awvalid (awvalid),
    .mem_axi_awready (awready),
    .mem_axi_awaddr  (awaddr),
    .mem_axi_awprot  (awprot),
    .mem_axi_wvalid  (wvalid),
    .mem_axi_wready  (wready),
    .mem_axi_wdata   (wdata),
    .mem_axi_wstrb   (wstrb),
    .mem_axi_bvalid  (bvalid),
    .mem_axi_bready  (bready),
    .mem_axi_arvalid (arvalid),
    .mem_axi_arready (arready),
    .mem_axi_araddr  (araddr),
    .mem_axi_arprot  (arprot),
    .mem_axi_rvalid  (rvalid),
    .mem_axi_rready  (rready),
    .mem_axi_rdata   (rdata),
    .console_valid   (console_valid),
    .console_data    (console_data),
    .tests_passed    (tests_passed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge sees the values the
  // following posedge will act on.
  always @(negedge clk) begin
    if (resetn && bvalid && bready) b_cnt++;
    if (resetn && console_valid) cons_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string name);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with bready held high: AW and W presented together.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    bit aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while ((awvalid || wvalid) && t < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      t++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    check("wr_accept", {31'b0, !(awvalid || wvalid)}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin
      tick();
      t++;
    end
    check("wr_bvalid", {31'b0, bvalid}, 32'd1);
    tick();
  endtask

  // Full read with rready held high; checks the one-cycle response latency.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    araddr = a;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      tick();
      t++;
    end
    tick();
    arvalid = 1'b0;
    check("rd_latency", {31'b0, rvalid}, 32'd1);
    check("rd_no_b2b", {31'b0, arready}, 32'd0);
    d = rdata;
    tick();
  endtask

  logic [31:0] got;
  int          base;

  initial begin
    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awprot = '0; arprot = '0;

    // Reset state
    #12;
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready", {31'b0, wready}, 32'd1);
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_console", {23'b0, console_valid, console_data}, 32'h0);
    check("rst_passed", {31'b0, tests_passed}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // AW+W same cycle: B one edge after the handshake edge
    awaddr = 32'h40; wdata = 32'hA5A5_1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("lat_awready_low", {31'b0, awready}, 32'd0);
    check("lat_b_not_yet", {31'b0, bvalid}, 32'd0);
    tick();
    check("lat_bvalid", {31'b0, bvalid}, 32'd1);
    check("lat_awready_back", {31'b0, awready}, 32'd1);
    tick();
    check("lat_b_done", {31'b0, bvalid}, 32'd0);
    axi_read(32'h40, got);
    check("rd_0x40", got, 32'hA5A5_1234);

    // Directed vector table
    add(1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, "w_word0");
    add(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, "w_100");
    add(1, 32'h0000_0100, 32'h0000_0000, 4'h8, "w_100_lane3");
    add(0, 32'h0000_0100, 32'h00AD_BEEF, 4'h0, "r_100_lane3");
    add(1, 32'h0000_0103, 32'h1234_5678, 4'h1, "w_103_lane0");
    add(0, 32'h0000_0102, 32'h00AD_BE78, 4'h0, "r_102_lowbits");
    add(1, 32'h0000_FFFC, 32'hCAFE_F00D, 4'hF, "w_last_word");
    add(0, 32'h0000_FFFC, 32'hCAFE_F00D, 4'h0, "r_last_word");
    add(1, 32'h0001_0000, 32'h5555_5555, 4'hF, "w_out_of_range");
    add(0, 32'h0001_0000, 32'h0000_0000, 4'h0, "r_out_of_range");
    add(0, 32'h0000_0000, 32'h0BAD_F00D, 4'h0, "r_word0_no_alias");
    add(0, CONSOLE,       32'h0000_0000, 4'h0, "r_console");
    add(0, 32'h3000_0000, 32'h0000_0000, 4'h0, "r_unmapped");
    add(1, 32'h0000_0044, 32'h1111_1111, 4'hF, "w_44_prior");
    add(1, 32'h0000_0080, 32'h0000_0000, 4'hF, "w_80_clear");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        axi_read(vecs[i].addr, got);
        check(vecs[i].name, got, vecs[i].data);
      end
    end

    // W three cycles ahead of AW, partial strobe
    base = b_cnt;
    wdata = 32'h0000_BB00; wstrb = 4'b0010; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready_low", {31'b0, wready}, 32'd0);
    repeat (2) begin
      tick();
      check("wfirst_no_b", {31'b0, bvalid}, 32'd0);
    end
    awaddr = 32'h44; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_b_not_yet", {31'b0, bvalid}, 32'd0);
    tick();
    check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
    repeat (3) tick();
    check("wfirst_one_b", b_cnt - base, 32'd1);
    axi_read(32'h44, got);
    check("rd_0x44_merge", got, 32'h1111_BB11);

    // B back-pressure with a second pair buffered
    base = b_cnt;
    bready = 1'b0;
    awaddr = 32'h48; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("bp_bvalid", {31'b0, bvalid}, 32'd1);
    awaddr = 32'h4C; wdata = 32'h2;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (4) begin
      check("bp_bvalid_hold", {31'b0, bvalid}, 32'd1);
      check("bp_ready_low", {30'b0, awready, wready}, 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    check("bp_bvalid_recommit", {31'b0, bvalid}, 32'd1);
    check("bp_ready_back", {30'b0, awready, wready}, 32'd3);
    tick();
    check("bp_bvalid_done", {31'b0, bvalid}, 32'd0);
    tick();
    check("bp_two_b", b_cnt - base, 32'd2);
    axi_read(32'h48, got);
    check("rd_0x48", got, 32'h1);
    axi_read(32'h4C, got);
    check("rd_0x4c", got, 32'h2);

    // Console pulse and sticky pass flag
    base = cons_cnt;
    awaddr = CONSOLE; wdata = 32'h41; wstrb = 4'h1;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("con_not_yet", {31'b0, console_valid}, 32'd0);
    tick();
    check("con_pulse", {23'b0, console_valid, console_data}, 32'h141);
    tick();
    check("con_pulse_end", {23'b0, console_valid, console_data}, 32'h041);
    axi_write(CONSOLE, 32'h42, 4'b1110);
    tick();
    check("con_count", cons_cnt - base, 32'd1);
    check("con_data_held", {24'b0, console_data}, 32'h41);
    axi_write(PASS, 32'd5, 4'hF);
    check("pass_wrong_data", {31'b0, tests_passed}, 32'd0);
    axi_write(PASS, 32'd123456789, 4'hF);
    check("pass_set", {31'b0, tests_passed}, 32'd1);
    axi_write(PASS, 32'd0, 4'hF);
    check("pass_sticky", {31'b0, tests_passed}, 32'd1);
    axi_read(PASS, got);
    check("rd_pass", got, 32'd1);

    // Read and write commit to the same word on the same edge
    awaddr = 32'h80; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h80; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("coll_bvalid", {31'b0, bvalid}, 32'd1);
    check("coll_rvalid", {31'b0, rvalid}, 32'd1);
    check("coll_old_data", rdata, 32'h0);
    tick();
    axi_read(32'h80, got);
    check("coll_new_data", got, 32'hFFFF_FFFF);

    // Asynchronous reset with B, R and a buffered AW outstanding
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h84; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    araddr = 32'h84; arvalid = 1'b1;
    awaddr = 32'h88; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("pre_rst_bv_rv", {30'b0, bvalid, rvalid}, 32'd3);
    check("pre_rst_aw_full", {31'b0, awready}, 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_bv_rv", {30'b0, bvalid, rvalid}, 32'd0);
    check("arst_passed", {31'b0, tests_passed}, 32'd0);
    check("arst_readies", {29'b0, awready, wready, arready}, 32'd7);
    check("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (2) tick();
    check("post_rst_no_stale_aw", {31'b0, bvalid}, 32'd0);
    awaddr = 32'h8C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    check("post_rst_bvalid", {31'b0, bvalid}, 32'd1);
    tick();
    axi_read(32'h8C, got);
    check("post_rst_rd", got, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4l_mem_responder.md
Name: axi4l_mem_responder

Overview:
Synthesizable AXI4-Lite responder that sits opposite the picorv32_axi initiator on the mem_axi_* bus. It serves a single-port on-chip word RAM and two MMIO registers: a console byte sink and a sticky test-pass flag. It replaces the behavioural memory model when the CPU subsystem runs on hardware next to the Harris accelerator. The bus carries no response codes; every accepted transaction completes with a bare B or R handshake.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words; byte address range 0 to 4*MEM_WORDS-1.
CONSOLE_ADDR, 32'h1000_0000, write-only console register address.
PASS_ADDR, 32'h2000_0000, test-pass register address.
PASS_MAGIC, 32'd123456789, data value that sets tests_passed.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_axi_awvalid  in  1  write address valid
mem_axi_awready  out  1  write address ready
mem_axi_awaddr  in  32  write byte address
mem_axi_awprot  in  3  ignored
mem_axi_wvalid  in  1  write data valid
mem_axi_wready  out  1  write data ready
mem_axi_wdata  in  32  write data
mem_axi_wstrb  in  4  byte lane enables
mem_axi_bvalid  out  1  write response valid
mem_axi_bready  in  1  write response ready
mem_axi_arvalid  in  1  read address valid
mem_axi_arready  out  1  read address ready
mem_axi_araddr  in  32  read byte address
mem_axi_arprot  in  3  ignored
mem_axi_rvalid  out  1  read data valid
mem_axi_rready  in  1  read data ready
mem_axi_rdata  out  32  read data
console_valid  out  1  one-cycle pulse per console byte
console_data  out  8  console byte
tests_passed  out  1  sticky pass flag

Behaviour:
- Reset (async, resetn=0): aw_full=0, w_full=0, bvalid=0, rvalid=0, rdata=0, console_valid=0, console_data=0, tests_passed=0. RAM contents are not reset.
- awready = !aw_full and wready = !w_full (combinational). Both are 1 during reset; this is legal because the initiator holds its valids low during reset.
- AW channel: on awvalid&&awready, latch awaddr and set aw_full.
- W channel: on wvalid&&wready, latch wdata and wstrb and set w_full.
- AW and W are independent. Either order, and the same cycle, are all accepted.
- Write commit occurs at an edge where aw_full && w_full && (!bvalid || bready). At that edge:
  - Perform the store.
  - Clear aw_full and w_full.
  - Set bvalid.
- bvalid holds until bvalid&&bready. If a new commit occurs in the same cycle as the bready handshake, bvalid stays 1.
- Latency: AW and W both handshaken at edge N → commit at edge N+1 → bvalid high from N+1.
- Back-pressure: a new AW/W can be accepted while B is pending. At most one further address/data pair is buffered; beyond that, ready stays low.
- Store targets:
  - RAM when awaddr < 4*MEM_WORDS. Word index = awaddr[..:2]; only lanes with wstrb[i]=1 are written; awaddr[1:0] is ignored.
  - awaddr == CONSOLE_ADDR and wstrb[0]: console_valid=1 for exactly one cycle after the commit edge, console_data=wdata[7:0] (held until the next console write).
  - awaddr == PASS_ADDR and wdata == PASS_MAGIC: tests_passed=1, held until reset. Any other data value to PASS_ADDR leaves the flag unchanged.
  - Any other address: dropped silently. A B response is still issued.
- Read FSM, states IDLE and RESP:
  - arready = (state==IDLE).
  - IDLE: on arvalid handshake, register rdata and go to RESP with rvalid=1.
  - RESP: hold rvalid and rdata stable until rready, then return to IDLE. No back-to-back reads without a one-cycle gap.
- Read data:
  - RAM range: the word at araddr[..:2].
  - PASS_ADDR: {31'b0, tests_passed}.
  - All other addresses (including CONSOLE_ADDR): 32'h0000_0000.
- Read/write collision: a read handshake and a write commit to the same word at the same edge returns the old data (read-before-write).
- Read and write paths are fully concurrent; neither blocks the other.
- Reset asserted mid-transaction: all pending AW/W/B/R state is discarded immediately. No partial store is performed after reset.

Test Plan:
- Write 0xA5A5_1234 to 0x40 with AW and W in the same cycle, bready=1 → bvalid rises 1 cycle later. Then read 0x40 → rvalid 1 cycle after AR with rdata=0xA5A5_1234.
- W sent 3 cycles before AW to 0x44 with wstrb=4'b0010 and wdata=0x0000_BB00 over a prior value 0x1111_1111 → a single bvalid; a readback of 0x44 returns 0x1111_BB11.
- Hold bready=0 for 5 cycles after a write → bvalid stays high. A second AW+W is accepted, then awready and wready drop until the first B handshakes; exactly two B handshakes total.
- Write 0x41 ('A') to 0x1000_0000 → console_valid high for exactly one cycle with console_data=0x41. Write 123456789 to 0x2000_0000 → tests_passed=1; a later write of 0 leaves it 1; a read of PASS_ADDR returns 1.
- Same-edge AR and write commit to 0x80 (old 0x0, new 0xFFFF_FFFF) → rdata=0x0; a subsequent read returns 0xFFFF_FFFF. A read of 0x3000_0000 returns 0.
- Assert resetn=0 while bvalid=1 and rvalid=1 → both drop asynchronously and tests_passed clears. After release, awready, wready and arready are 1 and the bus operates normally.
